unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Single-port memory arbiter and access sequencer that lets the pipeline's instruction-fetch stage and data-memory stage share one unified memory. Accepts one request per requester, grants one at a time (data priority with fetch anti-starvation), drives the memory port through a fixed-latency access FSM, and returns registered read data with a one-cycle valid pulse. Sits between the IF/MEM pipeline stages and the memory, and supplies the stall signals that freeze the pipeline registers.

## Interface
- ADDR_WIDTH, 32, address width of both requesters and the memory port
- DATA_WIDTH, 32, data width
- MEM_LATENCY, 1, cycles from mem_en_o to valid mem_rdata_i; legal range 1..8
- STARVE_LIMIT, 3, consecutive data grants won against a pending fetch before fetch is forced; legal 1..15

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_gnt_o  out  1  one-cycle pulse: fetch request accepted
- if_rvalid_o  out  1  one-cycle pulse: if_rdata_o valid
- if_rdata_o  out  DATA_WIDTH  fetched instruction, held until next fetch response
- dm_req_i  in  1  data request; held with dm_we_i/addr/wdata stable until dm_gnt_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_WIDTH  data address
- dm_wdata_i  in  DATA_WIDTH  write data
- dm_gnt_o  out  1  one-cycle pulse: data request accepted
- dm_rvalid_o  out  1  one-cycle pulse: read data valid / write complete
- dm_rdata_o  out  DATA_WIDTH  read data, held until next data read response
- mem_en_o, mem_we_o  out  1  memory enable / write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data
- stall_if_o, stall_mem_o  out  1  stage stall requests
- busy_o  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request, winner chosen and registered; next state ISSUE. No request: stay.
- Arbitration: data wins, except if_req_i=1 and starve_cnt==STARVE_LIMIT, then fetch wins.
- starve_cnt (4 bits): +1 when data wins while if_req_i=1; cleared when fetch wins or when if_req_i=0 at arbitration; saturates at STARVE_LIMIT.
- ISSUE (1 cycle): mem_en_o=1, mem_addr_o/mem_we_o/mem_wdata_o from winner (mem_we_o=0, mem_wdata_o=0 for fetch); winner's gnt pulses; latency counter loaded MEM_LATENCY-1; next WAIT.
- WAIT: lasts exactly MEM_LATENCY cycles; counter decrements; at the edge ending the last WAIT cycle, mem_rdata_i captured into the winner's rdata register (reads only); next RESP.
- RESP (1 cycle): winner's rvalid pulses; writes pulse dm_rvalid_o with dm_rdata_o unchanged; next IDLE.
- mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o are 0 outside ISSUE.
- stall_if_o = if_req_i & ~if_rvalid_o; stall_mem_o = dm_req_i & ~dm_rvalid_o (combinational).
- A requester whose req is still high in IDLE after its response is a new request.
- busy_o = (state != IDLE).

## Timing
- Reset (reset=0): state IDLE, all outputs 0, rdata registers 0, starve_cnt 0, counter 0; takes effect immediately.
- Reset mid-access: access aborted, no gnt/rvalid emitted, late memory data ignored.
- Arbitration sampled in IDLE cycle T; ISSUE = T+1; WAIT = T+2..T+1+MEM_LATENCY; RESP = T+2+MEM_LATENCY; IDLE again T+3+MEM_LATENCY.
- Request-to-rvalid latency MEM_LATENCY+2 cycles; throughput one access per MEM_LATENCY+3 cycles.
- Requests changing outside IDLE have no effect until next IDLE.
- Simultaneous requests: data first unless starvation rule applies; loser stays pending, stall remains high.

## Test plan
- MEM_LATENCY=2, fetch only: if_req_i=1 addr 0x0000_0040 at cycle 0 -> if_gnt_o and mem_en_o cycle 1 with mem_addr_o=0x40; memory returns 0x0051_0113 in cycle 3 -> if_rvalid_o cycle 4, if_rdata_o=0x0051_0113; stall_if_o high cycles 0-3.
- Simultaneous if_req_i and dm_req_i (read 0x100), STARVE_LIMIT=3 -> dm_gnt_o first, fetch granted in next IDLE; stall_if_o high throughout.
- Both requests held continuously, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I.
- Data write addr 0x10 wdata 0xDEAD_BEEF -> ISSUE cycle mem_we_o=1, mem_wdata_o=0xDEAD_BEEF; dm_rvalid_o pulse in RESP; dm_rdata_o retains prior value.
- MEM_LATENCY=4: response exactly 6 cycles after request; busy_o high 6 cycles per access.
- reset driven low during WAIT -> all outputs 0 same cycle, no rvalid after release; next request serviced normally.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-port memory between the
// instruction-fetch and data-memory stages. Data has priority, with a
// starvation counter that forces a fetch grant after STARVE_LIMIT
// consecutive data wins. Each access runs IDLE -> ISSUE -> WAIT -> RESP.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,

    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,

    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  stall_if_o,
    output logic                  stall_mem_o,
    output logic                  busy_o
);

    localparam int unsigned CNT_W    = 3;
    localparam int unsigned STARVE_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [1:0]            state, state_d;
    logic [CNT_W-1:0]      lat_cnt, lat_cnt_d;
    logic [STARVE_W-1:0]   starve_cnt, starve_cnt_d;
    logic                  win_dm, win_dm_d;
    logic                  win_we, win_we_d;

    logic                  if_gnt_d, dm_gnt_d;
    logic                  if_rvalid_d, dm_rvalid_d;
    logic [DATA_WIDTH-1:0] if_rdata_d, dm_rdata_d;
    logic                  mem_en_d, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    logic                  busy_d;
    logic                  fetch_wins;

    // Next-state, arbitration and next-output decode
    always_comb begin
        state_d      = state;
        lat_cnt_d    = lat_cnt;
        starve_cnt_d = starve_cnt;
        win_dm_d     = win_dm;
        win_we_d     = win_we;
        if_gnt_d     = 1'b0;
        dm_gnt_d     = 1'b0;
        if_rvalid_d  = 1'b0;
        dm_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_o;
        dm_rdata_d   = dm_rdata_o;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        fetch_wins   = 1'b0;

        case (state)
            S_IDLE: begin
                if (if_req_i || dm_req_i) begin
                    // Fetch wins when alone or when it has been starved long enough
                    fetch_wins = if_req_i && (!dm_req_i || (starve_cnt == STARVE_MAX));
                    state_d    = S_ISSUE;
                    mem_en_d   = 1'b1;
                    if (fetch_wins) begin
                        win_dm_d     = 1'b0;
                        win_we_d     = 1'b0;
                        if_gnt_d     = 1'b1;
                        mem_addr_d   = if_addr_i;
                        starve_cnt_d = '0;
                    end else begin
                        win_dm_d    = 1'b1;
                        win_we_d    = dm_we_i;
                        dm_gnt_d    = 1'b1;
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        if (!if_req_i) begin
                            starve_cnt_d = '0;
                        end else if (starve_cnt != STARVE_MAX) begin
                            starve_cnt_d = starve_cnt + STARVE_W'(1);
                        end
                    end
                end
            end
            S_ISSUE: begin
                lat_cnt_d = LAT_LOAD;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt == '0) begin
                    state_d = S_RESP;
                    if (win_dm) begin
                        dm_rvalid_d = 1'b1;
                        if (!win_we) begin
                            dm_rdata_d = mem_rdata_i;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata_i;
                    end
                end else begin
                    lat_cnt_d = lat_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            win_dm      <= 1'b0;
            win_we      <= 1'b0;
            if_gnt_o    <= 1'b0;
            dm_gnt_o    <= 1'b0;
            if_rvalid_o <= 1'b0;
            dm_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_d;
            lat_cnt     <= lat_cnt_d;
            starve_cnt  <= starve_cnt_d;
            win_dm      <= win_dm_d;
            win_we      <= win_we_d;
            if_gnt_o    <= if_gnt_d;
            dm_gnt_o    <= dm_gnt_d;
            if_rvalid_o <= if_rvalid_d;
            dm_rvalid_o <= dm_rvalid_d;
            if_rdata_o  <= if_rdata_d;
            dm_rdata_o  <= dm_rdata_d;
            mem_en_o    <= mem_en_d;
            mem_we_o    <= mem_we_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            busy_o      <= busy_d;
        end
    end

    // Stage stalls; forced low while reset is asserted so every output reads 0
    assign stall_if_o  = reset & if_req_i & ~if_rvalid_o;
    assign stall_mem_o = reset & dm_req_i & ~dm_rvalid_o;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed warm-up, then randomized traffic
// with mid-access resets, checked against a transaction-timing model.
module tb_unified_mem_arbiter;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned LAT    = 2;
    localparam int unsigned SLIM   = 3;
    localparam int          NCYC   = 2000;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          dm_req_i, dm_we_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic          dm_gnt_o, dm_rvalid_o;
    logic [DW-1:0] dm_rdata_o;
    logic          mem_en_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          stall_if_o, stall_mem_o, busy_o;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
        .dm_rdata_o(dm_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one access record plus arithmetic on its start cycle
    logic [DW-1:0] rd_hist [0:NCYC+16];
    int            free_at;
    logic          has_txn;
    int            t0;
    logic          t_dm, t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    int            starve;
    logic [DW-1:0] exp_if_rdata, exp_dm_rdata;
    logic          if_granted, dm_granted;
    logic          first_dm;
    logic [7:0]    gnt_is_if;
    int            n_gnt;
    int            n_resets;

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_if_gnt"},    64'(if_gnt_o),    64'd0);
        chk({pfx, "_dm_gnt"},    64'(dm_gnt_o),    64'd0);
        chk({pfx, "_if_rvalid"}, 64'(if_rvalid_o), 64'd0);
        chk({pfx, "_dm_rvalid"}, 64'(dm_rvalid_o), 64'd0);
        chk({pfx, "_if_rdata"},  64'(if_rdata_o),  64'd0);
        chk({pfx, "_dm_rdata"},  64'(dm_rdata_o),  64'd0);
        chk({pfx, "_mem_en"},    64'(mem_en_o),    64'd0);
        chk({pfx, "_mem_we"},    64'(mem_we_o),    64'd0);
        chk({pfx, "_mem_addr"},  64'(mem_addr_o),  64'd0);
        chk({pfx, "_mem_wdata"}, 64'(mem_wdata_o), 64'd0);
        chk({pfx, "_stall_if"},  64'(stall_if_o),  64'd0);
        chk({pfx, "_stall_mem"}, 64'(stall_mem_o), 64'd0);
        chk({pfx, "_busy"},      64'(busy_o),      64'd0);
    endtask

    // Apply the arbitration rule to the requests presented in cycle c
    task automatic model_arbitrate(input int c);
        logic fw;
        if (c >= free_at && (if_req_i || dm_req_i)) begin
            fw = if_req_i && (!dm_req_i || starve == int'(SLIM));
            if (fw)            starve = 0;
            else if (if_req_i) starve = (starve < int'(SLIM)) ? starve + 1 : starve;
            else               starve = 0;
            has_txn = 1'b1;
            t0      = c;
            free_at = c + 3 + int'(LAT);
            t_dm    = !fw;
            t_we    = fw ? 1'b0 : dm_we_i;
            t_addr  = fw ? if_addr_i : dm_addr_i;
            t_wdata = fw ? '0 : dm_wdata_i;
            if (fw) if_granted = 1'b1;
            else    dm_granted = 1'b1;
        end
    endtask

    task automatic process_cycle(input int c);
        logic iss, rsp, bsy, rsp_if, rsp_dm;
        int   mode;
        mode = (c < 10) ? 0 : (c < 60) ? 1 : 2;

        iss    = has_txn && (c == t0 + 1);
        rsp    = has_txn && (c == t0 + 2 + int'(LAT));
        bsy    = has_txn && (c >= t0 + 1) && (c <= t0 + 2 + int'(LAT));
        rsp_if = rsp && !t_dm;
        rsp_dm = rsp && t_dm;
        if (rsp_if)            exp_if_rdata = rd_hist[t0 + 1 + int'(LAT)];
        if (rsp_dm && !t_we)   exp_dm_rdata = rd_hist[t0 + 1 + int'(LAT)];

        chk("busy",      64'(busy_o),      64'(bsy));
        chk("mem_en",    64'(mem_en_o),    64'(iss));
        chk("mem_we",    64'(mem_we_o),    64'(iss && t_we));
        chk("mem_addr",  64'(mem_addr_o),  iss ? 64'(t_addr)  : 64'd0);
        chk("mem_wdata", 64'(mem_wdata_o), iss ? 64'(t_wdata) : 64'd0);
        chk("if_gnt",    64'(if_gnt_o),    64'(iss && !t_dm));
        chk("dm_gnt",    64'(dm_gnt_o),    64'(iss && t_dm));
        chk("if_rvalid", 64'(if_rvalid_o), 64'(rsp_if));
        chk("dm_rvalid", 64'(dm_rvalid_o), 64'(rsp_dm));
        chk("if_rdata",  64'(if_rdata_o),  64'(exp_if_rdata));
        chk("dm_rdata",  64'(dm_rdata_o),  64'(exp_dm_rdata));

        // Hand-derived expectations for the directed warm-up
        if (c == 1) begin
            chk("dir_if_gnt",   64'(if_gnt_o),   64'd1);
            chk("dir_mem_addr", 64'(mem_addr_o), 64'h40);
        end
        if (c == 4) begin
            chk("dir_if_rvalid", 64'(if_rvalid_o), 64'd1);
            chk("dir_if_rdata",  64'(if_rdata_o),  64'h0051_0113);
        end
        if (c == 11) begin
            chk("dir_wr_we",    64'(mem_we_o),    64'd1);
            chk("dir_wr_addr",  64'(mem_addr_o),  64'h10);
            chk("dir_wr_wdata", 64'(mem_wdata_o), 64'hDEAD_BEEF);
        end
        if (c == 14) begin
            chk("dir_wr_rvalid", 64'(dm_rvalid_o), 64'd1);
            chk("dir_wr_rdata",  64'(dm_rdata_o),  64'd0);
        end
        if (mode == 1 && (if_gnt_o || dm_gnt_o) && n_gnt < 8) begin
            gnt_is_if[n_gnt] = if_gnt_o;
            n_gnt++;
        end
        if (c == 60) chk("grant_order", 64'(gnt_is_if), 64'h88);

        // Requesters release once answered
        if (rsp_if) begin if_req_i = 1'b0; if_granted = 1'b0; end
        if (rsp_dm) begin dm_req_i = 1'b0; dm_granted = 1'b0; end

        // Memory read data: fresh random word every cycle
        mem_rdata_i = (c == 3) ? 32'h0051_0113 : $urandom;
        rd_hist[c]  = mem_rdata_i;

        if (!if_req_i) begin
            if ((mode == 0 && c == 0) || mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                if_req_i  = 1'b1;
                if_addr_i = (mode == 0) ? 32'h40 : ($urandom & 32'hFFFF_FFFC);
            end
        end
        if (!dm_req_i) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                dm_req_i = 1'b1;
                if (first_dm) begin
                    first_dm   = 1'b0;
                    dm_we_i    = 1'b1;
                    dm_addr_i  = 32'h10;
                    dm_wdata_i = 32'hDEAD_BEEF;
                end else begin
                    dm_we_i    = 1'($urandom_range(0, 1));
                    dm_addr_i  = $urandom & 32'hFFFF_FFFC;
                    dm_wdata_i = $urandom;
                end
            end
        end

        model_arbitrate(c);

        #1;
        chk("stall_if",  64'(stall_if_o),  64'(if_req_i && !rsp_if));
        chk("stall_mem", 64'(stall_mem_o), 64'(dm_req_i && !rsp_dm));

        // Occasional reset pulse while an access is waiting on memory
        if (mode == 2 && has_txn && c >= t0 + 2 && c <= t0 + 1 + int'(LAT)
            && $urandom_range(0, 9) == 0) begin
            #1 reset = 1'b0;
            #1 chk_all_zero("rst_mid");
            #1 reset = 1'b1;
            n_resets++;
            has_txn      = 1'b0;
            starve       = 0;
            exp_if_rdata = '0;
            exp_dm_rdata = '0;
            if_granted   = 1'b0;
            dm_granted   = 1'b0;
            free_at      = c;
            model_arbitrate(c);
        end
    endtask

    initial begin
        int cyc;
        reset      = 1'b0;
        if_req_i   = 1'b0;
        if_addr_i  = '0;
        dm_req_i   = 1'b0;
        dm_we_i    = 1'b0;
        dm_addr_i  = '0;
        dm_wdata_i = '0;
        mem_rdata_i = '0;
        free_at    = 0;
        has_txn    = 1'b0;
        t0         = 0;
        t_dm       = 1'b0;
        t_we       = 1'b0;
        t_addr     = '0;
        t_wdata    = '0;
        starve     = 0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        if_granted = 1'b0;
        dm_granted = 1'b0;
        first_dm   = 1'b1;
        gnt_is_if  = '0;
        n_gnt      = 0;
        n_resets   = 0;

        #1 chk_all_zero("rst_init");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        cyc = -1;
        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            process_cycle(cyc);
        end

        chk("resets_seen", 64'(n_resets > 0), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
